// File: rtl/acl_tilt_pkg.sv
// Shared encodings and default constants for the accelerometer tilt-gesture controller.
package acl_tilt_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned SUM_W    = 10;
    localparam int unsigned MAG_W    = 9;

    localparam int unsigned DEF_SAMPLE_DIV   = 1000000;
    localparam int unsigned DEF_TH_ON        = 40;
    localparam int unsigned DEF_TH_OFF       = 24;
    localparam int unsigned DEF_STABLE_TICKS = 5;
    localparam int unsigned DEF_REPEAT_FIRST = 50;
    localparam int unsigned DEF_REPEAT_NEXT  = 20;

    typedef enum logic [2:0] {
        ZONE_NONE  = 3'd0,
        ZONE_LEFT  = 3'd1,
        ZONE_RIGHT = 3'd2,
        ZONE_UP    = 3'd3,
        ZONE_DOWN  = 3'd4
    } zone_e;

    typedef enum logic [1:0] {
        ST_NEUTRAL = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_FIRE    = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    // Magnitude of a signed sample; 9 bits so that -128 maps to 128.
    function automatic logic [MAG_W-1:0] abs_mag(input logic [SAMPLE_W-1:0] v);
        logic [MAG_W-1:0] ext;
        ext = {v[SAMPLE_W-1], v};
        return v[SAMPLE_W-1] ? (~ext + MAG_W'(1)) : ext;
    endfunction

endpackage

// File: rtl/acl_tilt_ctrl_avg4.sv
// One-axis 4-tap moving average, advanced on the sample tick.
module acl_avg4
    import acl_tilt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [SAMPLE_W-1:0] din,
    output logic [SAMPLE_W-1:0] avg
);

    logic signed [SAMPLE_W-1:0] din_s;
    logic signed [SAMPLE_W-1:0] h0;
    logic signed [SAMPLE_W-1:0] h1;
    logic signed [SAMPLE_W-1:0] h2;
    logic signed [SUM_W-1:0]    sum_c;

    assign din_s = din;

    // Window is the incoming sample plus the three previously captured ones.
    assign sum_c = SUM_W'(din_s) + SUM_W'(h0) + SUM_W'(h1) + SUM_W'(h2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h0  <= '0;
            h1  <= '0;
            h2  <= '0;
            avg <= '0;
        end else if (tick) begin
            h0  <= din_s;
            h1  <= h0;
            h2  <= h1;
            avg <= SAMPLE_W'(sum_c >>> 2);
        end
    end

endmodule

// File: rtl/acl_tilt_ctrl.sv
// Tilt gesture controller: averaged X/Y samples to debounced next/prev/volume pulses.
module acl_tilt_ctrl
    import acl_tilt_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int unsigned TH_ON        = DEF_TH_ON,
    parameter int unsigned TH_OFF       = DEF_TH_OFF,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int unsigned REPEAT_FIRST = DEF_REPEAT_FIRST,
    parameter int unsigned REPEAT_NEXT  = DEF_REPEAT_NEXT
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x_data,
    input  logic [7:0] y_data,
    output logic       next_trk,
    output logic       prev_trk,
    output logic       vol_up,
    output logic       vol_down,
    output logic [2:0] tilt_zone,
    output logic [7:0] avg_x,
    output logic [7:0] avg_y
);

    localparam int unsigned DIV_W   = $clog2(SAMPLE_DIV);
    localparam int unsigned QUAL_W  = $clog2(STABLE_TICKS + 2);
    localparam int unsigned REP_MAX = (REPEAT_FIRST > REPEAT_NEXT) ? REPEAT_FIRST : REPEAT_NEXT;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 2);

    logic [DIV_W-1:0]  div_cnt;
    logic              tick_c;

    state_e            state_q, state_d;
    zone_e             cand_q, cand_d;
    zone_e             tilt_zone_q, tilt_zone_d;
    logic [QUAL_W-1:0] qual_q, qual_d, qual_inc_c;
    logic [REP_W-1:0]  rep_q, rep_d, rep_inc_c, rep_lim_c;
    logic              first_q, first_d;
    logic [3:0]        pulse_q, pulse_d;

    logic [MAG_W-1:0]  mag_x_c, mag_y_c, own_mag_c;
    zone_e             zone_c;
    logic              cand_x_c, cand_neg_c, own_neg_c, release_c;

    assign tick_c = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        div_cnt <= '0;
        else if (tick_c) div_cnt <= '0;
        else             div_cnt <= div_cnt + DIV_W'(1);
    end

    acl_avg4 u_avg_x (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_c),
        .din  (x_data),
        .avg  (avg_x)
    );

    acl_avg4 u_avg_y (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_c),
        .din  (y_data),
        .avg  (avg_y)
    );

    assign mag_x_c = abs_mag(avg_x);
    assign mag_y_c = abs_mag(avg_y);

    // Entry zone: dominant axis (X wins ties) must strictly exceed the on-threshold.
    always_comb begin
        zone_c = ZONE_NONE;
        if (mag_x_c >= mag_y_c) begin
            if (mag_x_c > MAG_W'(TH_ON)) begin
                if (avg_x[7]) zone_c = ZONE_LEFT;
                else          zone_c = ZONE_RIGHT;
            end
        end else if (mag_y_c > MAG_W'(TH_ON)) begin
            if (avg_y[7]) zone_c = ZONE_DOWN;
            else          zone_c = ZONE_UP;
        end
    end

    // Hold release looks only at the held zone's own axis, ignoring dominance changes.
    assign cand_x_c   = (cand_q == ZONE_LEFT) || (cand_q == ZONE_RIGHT);
    assign cand_neg_c = (cand_q == ZONE_LEFT) || (cand_q == ZONE_DOWN);
    assign own_mag_c  = cand_x_c ? mag_x_c : mag_y_c;
    assign own_neg_c  = cand_x_c ? avg_x[7] : avg_y[7];
    assign release_c  = (own_mag_c <= MAG_W'(TH_OFF)) || (own_neg_c != cand_neg_c);

    assign qual_inc_c = qual_q + QUAL_W'(1);
    assign rep_inc_c  = rep_q + REP_W'(1);
    assign rep_lim_c  = first_q ? REP_W'(REPEAT_FIRST) : REP_W'(REPEAT_NEXT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_NEUTRAL;
            cand_q      <= ZONE_NONE;
            tilt_zone_q <= ZONE_NONE;
            qual_q      <= '0;
            rep_q       <= '0;
            first_q     <= 1'b0;
            pulse_q     <= '0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            tilt_zone_q <= tilt_zone_d;
            qual_q      <= qual_d;
            rep_q       <= rep_d;
            first_q     <= first_d;
            pulse_q     <= pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        tilt_zone_d = tilt_zone_q;
        qual_d      = qual_q;
        rep_d       = rep_q;
        first_d     = first_q;
        pulse_d     = '0;

        unique case (state_q)
            ST_NEUTRAL: begin
                tilt_zone_d = ZONE_NONE;
                if (tick_c && (zone_c != ZONE_NONE)) begin
                    cand_d  = zone_c;
                    qual_d  = QUAL_W'(1);
                    first_d = 1'b1;
                    state_d = (STABLE_TICKS <= 1) ? ST_FIRE : ST_QUALIFY;
                end
            end
            ST_QUALIFY: begin
                tilt_zone_d = ZONE_NONE;
                if (tick_c) begin
                    if (zone_c == cand_q) begin
                        qual_d = qual_inc_c;
                        if (qual_inc_c >= QUAL_W'(STABLE_TICKS)) state_d = ST_FIRE;
                    end else begin
                        state_d = ST_NEUTRAL;
                    end
                end
            end
            ST_FIRE: begin
                tilt_zone_d = cand_q;
                rep_d       = '0;
                state_d     = ST_HOLD;
                case (cand_q)
                    ZONE_RIGHT: pulse_d[0] = 1'b1;
                    ZONE_LEFT:  pulse_d[1] = 1'b1;
                    ZONE_UP:    pulse_d[2] = 1'b1;
                    ZONE_DOWN:  pulse_d[3] = 1'b1;
                    default:    pulse_d    = '0;
                endcase
            end
            ST_HOLD: begin
                if (tick_c) begin
                    if (release_c) begin
                        state_d     = ST_NEUTRAL;
                        tilt_zone_d = ZONE_NONE;
                    end else if (!cand_x_c) begin
                        // Volume auto-repeat; track skips fire once per hold.
                        rep_d = rep_inc_c;
                        if (rep_inc_c >= rep_lim_c) begin
                            state_d = ST_FIRE;
                            first_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = ST_NEUTRAL;
        endcase
    end

    assign next_trk  = pulse_q[0];
    assign prev_trk  = pulse_q[1];
    assign vol_up    = pulse_q[2];
    assign vol_down  = pulse_q[3];
    assign tilt_zone = tilt_zone_q;

endmodule
